// File: rtl/world_pkg.sv
// Shared constants and types for the world-map tile write path.
// Tile convention: even index = solid, odd index = passable.
package world_pkg;

    localparam int unsigned CELLS_PER_ROW    = 40;
    localparam int unsigned CELL_ROWS        = 30;
    localparam int unsigned CELLS_PER_SCREEN = 1200;

    localparam int unsigned COL_W  = 8;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned TILE_W = 5;
    localparam int unsigned ADDR_W = 13;

    localparam logic [TILE_W-1:0] TILE_SKY    = 5'd1;
    localparam logic [TILE_W-1:0] TILE_BRICK  = 5'd2;
    localparam logic [TILE_W-1:0] TILE_QBLOCK = 5'd4;
    localparam logic [TILE_W-1:0] TILE_USED   = 5'd6;

    typedef enum logic [1:0] {
        OP_SET   = 2'b00,
        OP_BUMP  = 2'b01,
        OP_BREAK = 2'b10,
        OP_CLEAR = 2'b11
    } tile_op_t;

    typedef enum logic [1:0] {
        DONE_UNCHANGED = 2'b00,
        DONE_WRITTEN   = 2'b01,
        DONE_COIN      = 2'b10,
        DONE_REJECT    = 2'b11
    } done_code_t;

    typedef struct packed {
        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        tile_op_t          op;
        logic [TILE_W-1:0] tile;
    } tile_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WRITE
    } wr_state_t;

endpackage

// File: rtl/tile_req_fifo.sv
// Synchronous request FIFO; pushes are dropped while full, pops ignored while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module tile_req_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push       = push_valid_i && !full_o;
    assign pop        = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            if (push && !pop)      count_q <= CNT_W'(count_q + 1'b1);
            else if (pop && !push) count_q <= CNT_W'(count_q - 1'b1);
        end
    end

endmodule

// File: rtl/world_tile_writer.sv
// Queues tile-modify requests and applies them to the world cell RAM by
// read-modify-write, starting a transaction only while vblank is high.
module world_tile_writer
    import world_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_SCREENS = 6
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        vblank_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_col_i,
    input  logic [4:0]  req_row_i,
    input  logic [1:0]  req_op_i,
    input  logic [4:0]  req_tile_i,
    output logic [12:0] ram_addr_o,
    output logic [4:0]  ram_wdata_o,
    output logic        ram_we_o,
    input  logic [4:0]  ram_rdata_i,
    output logic        done_valid_o,
    output logic [1:0]  done_code_o,
    output logic [4:0]  done_old_tile_o,
    output logic        busy_o
);

    localparam int unsigned REQ_W = $bits(tile_req_t);

    wr_state_t         state_q, state_d;
    tile_req_t         req_q, req_d, head;
    logic              ok_q, ok_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [TILE_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              done_valid_q, done_valid_d;
    logic [1:0]        done_code_q, done_code_d;
    logic [TILE_W-1:0] done_old_q, done_old_d;

    logic [REQ_W-1:0]  head_raw;
    logic              fifo_empty, fifo_full, pop_c;
    logic [COL_W-1:0]  screen_c, col_mod_c;
    logic [ADDR_W-1:0] head_addr_c;
    logic              head_ok_c;
    logic [TILE_W-1:0] new_tile_c;
    logic              coin_c;

    tile_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_valid_i (req_valid_i),
        .push_data_i  ({req_col_i, req_row_i, req_op_i, req_tile_i}),
        .pop_i        (pop_c),
        .pop_data_o   (head_raw),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    assign head = head_raw;

    // Screen index by comparator chain against multiples of 40 (no divider).
    always_comb begin
        screen_c = '0;
        for (int s = 1; s < int'(NUM_SCREENS); s++) begin
            if (head.col >= COL_W'(CELLS_PER_ROW * s)) screen_c = COL_W'(s);
        end
        col_mod_c   = head.col - screen_c * COL_W'(CELLS_PER_ROW);
        head_addr_c = ADDR_W'(col_mod_c)
                    + ADDR_W'(head.row) * ADDR_W'(CELLS_PER_ROW)
                    + ADDR_W'(screen_c) * ADDR_W'(CELLS_PER_SCREEN);
        head_ok_c   = (32'(head.col) < CELLS_PER_ROW * NUM_SCREENS)
                   && (32'(head.row) < CELL_ROWS);
    end

    // Replacement tile for the popped op, given the tile just read.
    always_comb begin
        new_tile_c = ram_rdata_i;
        coin_c     = 1'b0;
        case (req_q.op)
            OP_SET:   new_tile_c = req_q.tile;
            OP_CLEAR: new_tile_c = TILE_SKY;
            OP_BREAK: if (ram_rdata_i == TILE_BRICK) new_tile_c = TILE_SKY;
            OP_BUMP: begin
                if (ram_rdata_i == TILE_QBLOCK) begin
                    new_tile_c = TILE_USED;
                    coin_c     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        ok_d         = ok_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        done_valid_d = 1'b0;
        done_code_d  = done_code_q;
        done_old_d   = done_old_q;
        pop_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && vblank_i) begin
                    pop_c   = 1'b1;
                    req_d   = head;
                    ok_d    = head_ok_c;
                    state_d = ST_ADDR;
                    if (head_ok_c) ram_addr_d = head_addr_c;
                end
            end
            ST_ADDR: begin
                if (!ok_q) begin
                    done_valid_d = 1'b1;
                    done_code_d  = DONE_REJECT;
                    done_old_d   = '0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                ram_we_d     = (new_tile_c != ram_rdata_i);
                ram_wdata_d  = new_tile_c;
                done_valid_d = 1'b1;
                done_old_d   = ram_rdata_i;
                if (coin_c)                         done_code_d = DONE_COIN;
                else if (new_tile_c != ram_rdata_i) done_code_d = DONE_WRITTEN;
                else                                done_code_d = DONE_UNCHANGED;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            ok_q         <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_code_q  <= '0;
            done_old_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            ok_q         <= ok_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            done_valid_q <= done_valid_d;
            done_code_q  <= done_code_d;
            done_old_q   <= done_old_d;
        end
    end

    assign req_ready_o     = !fifo_full;
    assign busy_o          = (state_q != ST_IDLE) || !fifo_empty;
    assign ram_addr_o      = ram_addr_q;
    assign ram_wdata_o     = ram_wdata_q;
    assign ram_we_o        = ram_we_q;
    assign done_valid_o    = done_valid_q;
    assign done_code_o     = done_code_q;
    assign done_old_tile_o = done_old_q;

endmodule

// File: tb/tb_world_tile_writer.sv
// Bench for world_tile_writer: behavioural RAM, done-pulse recorder, and
// a map-level reference model for the randomized request stream.
module tb_world_tile_writer;

    typedef struct packed {
        logic [7:0] col;
        logic [4:0] row;
        logic [1:0] op;
        logic [4:0] tile;
    } req_t;

    typedef struct packed {
        logic [1:0]  code;
        logic [4:0]  old;
        logic        we;
        logic [12:0] addr;
        logic [4:0]  wdata;
        int          cyc;
    } obs_t;

    typedef struct packed {
        logic [1:0]  code;
        logic [4:0]  old;
        logic        we;
        logic [12:0] addr;
        logic [4:0]  wdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset, vblank, req_valid, req_ready;
    logic [7:0]  req_col;
    logic [4:0]  req_row, req_tile, ram_wdata, ram_rdata, done_old_tile;
    logic [1:0]  req_op, done_code;
    logic [12:0] ram_addr;
    logic        ram_we, done_valid, busy;

    logic        tb_we;
    logic [12:0] tb_addr;
    logic [4:0]  tb_wdata;
    logic [4:0]  mem     [0:8191];
    logic [4:0]  ref_mem [0:8191];

    obs_t obs_q[$];
    int   cyc = 0;
    int   we_count = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    world_tile_writer #(.FIFO_DEPTH(4), .NUM_SCREENS(6)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .vblank_i        (vblank),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_col_i       (req_col),
        .req_row_i       (req_row),
        .req_op_i        (req_op),
        .req_tile_i      (req_tile),
        .ram_addr_o      (ram_addr),
        .ram_wdata_o     (ram_wdata),
        .ram_we_o        (ram_we),
        .ram_rdata_i     (ram_rdata),
        .done_valid_o    (done_valid),
        .done_code_o     (done_code),
        .done_old_tile_o (done_old_tile),
        .busy_o          (busy)
    );

    // World RAM: one-cycle read latency; bench port preloads cells.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we)     mem[ram_addr] <= ram_wdata;
        else if (tb_we) mem[tb_addr]  <= tb_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) we_count <= we_count + 1;
        if (done_valid) obs_q.push_back('{done_code, done_old_tile, ram_we, ram_addr, ram_wdata, cyc});
    end

    function automatic int model_addr(input int c, input int r);
        return (c % 40) + r * 40 + (c / 40) * 1200;
    endfunction

    function automatic req_t mk(input int c, input int r, input int op, input int t);
        req_t q;
        q.col = 8'(c); q.row = 5'(r); q.op = 2'(op); q.tile = 5'(t);
        return q;
    endfunction

    // Map-level effect of one request on ref_mem.
    task automatic model_op(input req_t r, output exp_t e);
        int a;
        logic [4:0] o, n;
        bit coin;
        e = '0;
        if (r.col >= 8'd240 || r.row >= 5'd30) begin
            e.code = 2'd3;
        end else begin
            a = model_addr(int'(r.col), int'(r.row));
            o = ref_mem[a]; n = o; coin = 0;
            case (r.op)
                2'd0: n = r.tile;
                2'd1: if (o == 5'd4) begin n = 5'd6; coin = 1; end
                2'd2: if (o == 5'd2) n = 5'd1;
                default: n = 5'd1;
            endcase
            e.old = o; e.we = (n != o); e.addr = 13'(a); e.wdata = n;
            e.code = coin ? 2'd2 : ((n != o) ? 2'd1 : 2'd0);
            ref_mem[a] = n;
        end
    endtask

    task automatic poke(input int a, input logic [4:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = 13'(a); tb_wdata = v;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic push(input req_t r, output bit acc, output int acyc);
        @(negedge clk);
        req_valid = 1'b1;
        req_col = r.col; req_row = r.row; req_op = r.op; req_tile = r.tile;
        acc = req_ready; acyc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) break;
            @(posedge clk);
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; vblank = 1'b0; req_valid = 1'b0; tb_we = 1'b0;
        req_col = '0; req_row = '0; req_op = '0; req_tile = '0; tb_addr = '0; tb_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if (ram_addr !== 13'd0) $display("FAIL reset_addr got %0d want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 5'd0) $display("FAIL reset_wdata got %0d want 0", ram_wdata); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we got %b want 0", ram_we); else n_pass++;
        n_checks++; if (done_valid !== 1'b0) $display("FAIL reset_done got %b want 0", done_valid); else n_pass++;
        n_checks++; if (done_code !== 2'd0) $display("FAIL reset_code got %0d want 0", done_code); else n_pass++;
        n_checks++; if (done_old_tile !== 5'd0) $display("FAIL reset_old got %0d want 0", done_old_tile); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_bump_coin();
        bit acc, ok; int acyc; obs_t o;
        poke(1325, 5'd4);
        vblank = 1'b1; obs_q.delete();
        push(mk(45, 3, 1, 0), acc, acyc);
        wait_obs(1, 20, ok);
        n_checks++; if (!ok) $display("FAIL bump_timeout got no done want 1 pulse"); else n_pass++;
        if (ok) begin
            o = obs_q.pop_front();
            n_checks++; if (o.cyc !== acyc + 4) $display("FAIL bump_latency got %0d want %0d", o.cyc - acyc, 4); else n_pass++;
            n_checks++; if (o.we !== 1'b1) $display("FAIL bump_we got %b want 1", o.we); else n_pass++;
            n_checks++; if (o.addr !== 13'd1325) $display("FAIL bump_addr got %0d want 1325", o.addr); else n_pass++;
            n_checks++; if (o.wdata !== 5'd6) $display("FAIL bump_wdata got %0d want 6", o.wdata); else n_pass++;
            n_checks++; if (o.code !== 2'd2) $display("FAIL bump_code got %0d want 2", o.code); else n_pass++;
            n_checks++; if (o.old !== 5'd4) $display("FAIL bump_old got %0d want 4", o.old); else n_pass++;
        end
        wait_idle();
        n_checks++; if (mem[1325] !== 5'd6) $display("FAIL bump_ram got %0d want 6", mem[1325]); else n_pass++;
    endtask

    task automatic test_break();
        bit acc, ok; int acyc; obs_t o;
        for (int pass = 0; pass < 2; pass++) begin
            poke(1160, (pass == 0) ? 5'd4 : 5'd2);
            obs_q.delete();
            push(mk(0, 29, 2, 0), acc, acyc);
            wait_obs(1, 20, ok);
            n_checks++; if (!ok) $display("FAIL break_timeout pass %0d got no done", pass); else n_pass++;
            if (ok) begin
                o = obs_q.pop_front();
                n_checks++; if (o.we !== (pass == 1)) $display("FAIL break_we pass %0d got %b want %b", pass, o.we, pass == 1); else n_pass++;
                n_checks++; if (o.code !== 2'(pass)) $display("FAIL break_code pass %0d got %0d want %0d", pass, o.code, pass); else n_pass++;
                n_checks++; if (o.old !== ((pass == 0) ? 5'd4 : 5'd2)) $display("FAIL break_old pass %0d got %0d", pass, o.old); else n_pass++;
            end
            wait_idle();
            n_checks++; if (mem[1160] !== ((pass == 0) ? 5'd4 : 5'd1)) $display("FAIL break_ram pass %0d got %0d", pass, mem[1160]); else n_pass++;
        end
    endtask

    task automatic test_vblank_gate();
        bit acc, ok; int acyc, we0;
        req_t r [3];
        obs_t o [3];
        r[0] = mk(85, 2, 0, 9); r[1] = mk(200, 29, 0, 12); r[2] = mk(239, 0, 0, 3);
        for (int i = 0; i < 3; i++) poke(model_addr(int'(r[i].col), int'(r[i].row)), 5'd0);
        vblank = 1'b0; obs_q.delete(); we0 = we_count;
        for (int i = 0; i < 3; i++) begin
            push(r[i], acc, acyc);
            n_checks++; if (acc !== 1'b1) $display("FAIL gate_ready push %0d got %b want 1", i, acc); else n_pass++;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (obs_q.size() != 0 || we_count != we0) $display("FAIL gate_idle got %0d dones %0d writes want 0", obs_q.size(), we_count - we0); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL gate_busy got %b want 1", busy); else n_pass++;
        vblank = 1'b1;
        wait_obs(3, 40, ok);
        n_checks++; if (!ok) $display("FAIL gate_timeout got %0d dones want 3", obs_q.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 3; i++) o[i] = obs_q.pop_front();
            for (int i = 1; i < 3; i++) begin
                n_checks++; if (o[i].cyc - o[i-1].cyc != 4) $display("FAIL gate_spacing %0d got %0d want 4", i, o[i].cyc - o[i-1].cyc); else n_pass++;
            end
        end
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem[model_addr(int'(r[i].col), int'(r[i].row))] !== r[i].tile)
                $display("FAIL gate_ram %0d got %0d want %0d", i, mem[model_addr(int'(r[i].col), int'(r[i].row))], r[i].tile);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        bit acc, ok; int acyc, a;
        vblank = 1'b0; obs_q.delete();
        for (int i = 0; i < 5; i++) poke(model_addr(i * 10, 5), 5'd0);
        for (int i = 0; i < 5; i++) begin
            push(mk(i * 10, 5, 0, 11 + i), acc, acyc);
            n_checks++; if (acc !== (i < 4)) $display("FAIL full_ready push %0d got %b want %b", i, acc, i < 4); else n_pass++;
        end
        repeat (5) @(posedge clk);
        vblank = 1'b1;
        wait_obs(4, 40, ok);
        repeat (12) @(posedge clk);
        n_checks++; if (obs_q.size() != 4) $display("FAIL full_count got %0d dones want 4", obs_q.size()); else n_pass++;
        wait_idle();
        a = model_addr(40, 5);
        n_checks++; if (mem[a] !== 5'd0) $display("FAIL full_dropped_ram got %0d want 0", mem[a]); else n_pass++;
        a = model_addr(30, 5);
        n_checks++; if (mem[a] !== 5'd14) $display("FAIL full_last_ram got %0d want 14", mem[a]); else n_pass++;
    endtask

    task automatic test_reject();
        bit acc, ok; int acyc, we0; obs_t o;
        vblank = 1'b1; obs_q.delete(); we0 = we_count;
        push(mk(240, 0, 0, 7), acc, acyc);
        push(mk(10, 30, 0, 7), acc, acyc);
        wait_obs(2, 30, ok);
        n_checks++; if (!ok) $display("FAIL reject_timeout got %0d dones want 2", obs_q.size()); else n_pass++;
        for (int i = 0; i < 2 && ok; i++) begin
            o = obs_q.pop_front();
            n_checks++; if (o.code !== 2'd3) $display("FAIL reject_code %0d got %0d want 3", i, o.code); else n_pass++;
            n_checks++; if (o.old !== 5'd0) $display("FAIL reject_old %0d got %0d want 0", i, o.old); else n_pass++;
        end
        wait_idle();
        n_checks++; if (we_count != we0) $display("FAIL reject_we got %0d writes want 0", we_count - we0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit acc; int acyc, dummy, we0;
        poke(45, 5'd0);
        vblank = 1'b1; obs_q.delete(); we0 = we_count;
        push(mk(5, 1, 0, 9), acc, acyc);
        push(mk(6, 1, 0, 9), acc, dummy);
        for (int i = 0; i < 10 && cyc < acyc + 3; i++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done_valid !== 1'b0 || ram_we !== 1'b0) $display("FAIL rstmid_pulse got done=%b we=%b want 0", done_valid, ram_we); else n_pass++;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_checks++; if (obs_q.size() != 0 || we_count != we0) $display("FAIL rstmid_after got %0d dones %0d writes want 0", obs_q.size(), we_count - we0); else n_pass++;
        n_checks++; if (mem[45] !== 5'd0) $display("FAIL rstmid_ram got %0d want 0", mem[45]); else n_pass++;
    endtask

    task automatic test_random();
        bit acc, ok; int acyc, a, c, r;
        req_t pend[$]; req_t q; exp_t e; obs_t o;
        logic [4:0] seed_tiles [5];
        seed_tiles[0] = 5'd1; seed_tiles[1] = 5'd2; seed_tiles[2] = 5'd4; seed_tiles[3] = 5'd6;
        for (int cc = 38; cc < 42; cc++) begin
            for (int rr = 28; rr < 30; rr++) begin
                seed_tiles[4] = 5'($urandom_range(0, 31));
                a = model_addr(cc, rr);
                ref_mem[a] = seed_tiles[$urandom_range(0, 4)];
                poke(a, ref_mem[a]);
            end
        end
        obs_q.delete();
        for (int i = 0; i < 40; i++) begin
            vblank = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            c = ($urandom_range(0, 7) == 0) ? 240 + $urandom_range(0, 15) : 38 + $urandom_range(0, 3);
            r = ($urandom_range(0, 7) == 0) ? 30 + $urandom_range(0, 1) : 28 + $urandom_range(0, 1);
            q = mk(c, r, $urandom_range(0, 3), $urandom_range(0, 31));
            push(q, acc, acyc);
            if (acc) pend.push_back(q);
        end
        vblank = 1'b1;
        wait_obs(pend.size(), 400, ok);
        repeat (10) @(posedge clk);
        n_checks++; if (obs_q.size() != pend.size()) $display("FAIL rand_count got %0d dones want %0d", obs_q.size(), pend.size()); else n_pass++;
        while (pend.size() > 0 && obs_q.size() > 0) begin
            model_op(pend.pop_front(), e);
            o = obs_q.pop_front();
            n_checks++; if (o.code !== e.code) $display("FAIL rand_code got %0d want %0d", o.code, e.code); else n_pass++;
            n_checks++; if (o.old !== e.old) $display("FAIL rand_old got %0d want %0d", o.old, e.old); else n_pass++;
            n_checks++; if (o.we !== e.we) $display("FAIL rand_we got %b want %b", o.we, e.we); else n_pass++;
            if (e.we) begin
                n_checks++; if (o.addr !== e.addr || o.wdata !== e.wdata)
                    $display("FAIL rand_write got %0d:%0d want %0d:%0d", o.addr, o.wdata, e.addr, e.wdata);
                else n_pass++;
            end
        end
        wait_idle();
        for (int cc = 38; cc < 42; cc++) begin
            for (int rr = 28; rr < 30; rr++) begin
                a = model_addr(cc, rr);
                n_checks++; if (mem[a] !== ref_mem[a]) $display("FAIL rand_ram addr %0d got %0d want %0d", a, mem[a], ref_mem[a]); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bump_coin();
        test_break();
        test_vblank_gate();
        test_full();
        test_reject();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/world_tile_writer.md
Name: world_tile_writer

Overview:
Write-side companion to the collision/tile-lookup path. It accepts tile-modify requests from game logic (block bumped, brick broken, tile set) addressed by logical cell column/row. It queues them and performs read-modify-write into the world cell RAM. The RAM is shared with the per-pixel collision and draw readers, so RAM writes start only during vertical blank; readers therefore see a frame-consistent map.

Parameters:
FIFO_DEPTH, 4, request queue depth (power of 2, ≥2)
NUM_SCREENS, 6, world width in screens; max column = 40*NUM_SCREENS-1 = 239

Ports:
Clk  in  1  system clock (clk_50 domain)
Reset  in  1  synchronous, active-high reset
vblank  in  1  high while VGA is outside the visible area; RAM transactions may start only while high
req_valid  in  1  request strobe
req_ready  out  1  queue not full; a request is accepted when req_valid & req_ready
req_col  in  8  logical cell column 0..239
req_row  in  5  cell row 0..29
req_op  in  2  00 SET, 01 BUMP, 10 BREAK, 11 CLEAR
req_tile  in  5  new tile index, used by SET only
ram_addr  out  13  world RAM address
ram_wdata  out  5  tile write data
ram_we  out  1  write enable, one cycle
ram_rdata  in  5  read data, valid 1 cycle after ram_addr
done_valid  out  1  one-cycle completion pulse
done_code  out  2  00 unchanged, 01 written, 10 coin (BUMP hit QBLOCK), 11 rejected (out of range)
done_old_tile  out  5  tile read before modification (0 on reject)
busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset values: req_ready=1, ram_addr=0, ram_wdata=0, ram_we=0, done_valid=0, done_code=0, done_old_tile=0, busy=0. Reset flushes the queue and forces the FSM to IDLE. Reset mid-transaction drops that transaction with no write and no done pulse.
- Queue: synchronous FIFO of {col,row,op,tile}. req_ready = !full, taken from registered state. When full, req_ready stays 0 even in a cycle where a pop occurs. Push and pop in the same cycle when not full or empty: count unchanged.
- Address: addr = (col mod 40) + row*40 + (col div 40)*1200. The screen index is computed by a comparator chain against 40, 80, …, 200; no divider. Reject the request if col ≥ 40*NUM_SCREENS or row ≥ 30.
- FSM states: IDLE, ADDR, READ, WRITE.
  - IDLE: if queue non-empty and vblank=1, pop the head and go to ADDR. If queue non-empty and vblank=0, wait.
  - ADDR: range check. If rejected, pulse done_valid with code 11 and return to IDLE; no RAM access. Otherwise register ram_addr and go to READ.
  - READ: capture ram_rdata into old tile, compute the new tile, go to WRITE.
  - WRITE: if new≠old, assert ram_we for one cycle with ram_wdata=new. Pulse done_valid the same cycle; return to IDLE.
- ram_addr is held stable from ADDR through WRITE.
- Accepted transaction: 4 cycles IDLE→IDLE; back-to-back requests give 1 op per 4 cycles.
- Once popped, a transaction completes even if vblank falls mid-transaction (at most 3 further cycles).
- Op semantics:
  - SET: new = req_tile.
  - CLEAR: new = TILE_SKY.
  - BREAK: if old = TILE_BRICK then new = TILE_SKY, else unchanged.
  - BUMP: if old = TILE_QBLOCK then new = TILE_USED with code 10, else unchanged.
- done_code: 01 if a write occurred and the op was not a coin BUMP; 00 if new = old.
- Tile convention: even tile index = solid, odd = passable. TILE_SKY=1, TILE_BRICK=2, TILE_QBLOCK=4, TILE_USED=6.

Decomposition:
- Package world_pkg: CELLS_PER_ROW=40, CELL_ROWS=30, CELLS_PER_SCREEN=1200, the TILE_* constants, the tile_op_t enum {OP_SET, OP_BUMP, OP_BREAK, OP_CLEAR} and the done-code enum.
- One sub-module, tile_req_fifo: parameterized synchronous FIFO with valid/ready push, pop, empty, full.
- Address and op logic stay in the top module.

Test Plan:
1. vblank=1, RAM[1325]=4, BUMP col=45 row=3 → ram_addr=1325; ram_we with wdata=6 in the 4th cycle after pop; done_code=10, done_old_tile=4.
2. BREAK col=0 row=29 with RAM[1160]=4 → no ram_we; done_code=00, done_old_tile=4. Repeat with RAM=2 → write 1, done_code=01.
3. vblank=0, push 3 SET requests → req_ready stays 1, no RAM activity, busy=1. Raise vblank → three done pulses, 4 cycles apart; RAM shows the writes.
4. Hold vblank=0 and push until full → req_ready=0 after 4 pushes; a 5th req_valid is ignored, and only 4 done pulses follow once vblank=1.
5. SET col=240 row=0 and SET col=10 row=30 → done_code=11 each; ram_we never asserted.
6. Assert Reset in the READ state → no ram_we, no done_valid; queue empty, req_ready=1, busy=0 on the next cycle.
